// File: rtl/iob_req_queue.sv
// iob_req_queue: two-entry FSB I/O request queue feeding the PDS I/O master, driving the two-level latch strobes.
// Optional abort of a stuck ACT phase when IOB_QUEUE_TIMEOUT_EN is defined.
module iob_req_queue #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT = 255
) (
  input  logic CLK,
  input  logic RES,
  input  logic IN_VALID,
  input  logic IN_RW,
  input  logic IN_LDS,
  input  logic IN_UDS,
  output logic IN_READY,
  output logic RD_DONE,
  output logic IOREQ,
  output logic IORW,
  output logic IOLDS,
  output logic IOUDS,
  input  logic IOACT,
  input  logic IODONE,
  output logic LE_IN,
  output logic LE_FWD,
  output logic QEMPTY,
  output logic ERR
);
  typedef enum logic [1:0] {IDLE, REQ, ACT, DONE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] act_sync, done_sync;
  logic act_s, done_s;
  logic [1:0] count, count_n;
  logic [2:0] slot0, slot1, slot0_n, slot1_n, entry;
  logic rd_out, promo, promo_n, le_in_n, le_fwd_n;
  logic accept, retire, abort;

  if (SYNC_STAGES < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("iob_req_queue: SYNC_STAGES must be >= 2 and TIMEOUT >= 1");
  end

  always_ff @(posedge CLK)
    if (RES) begin
      act_sync <= '0;
      done_sync <= '0;
    end else begin
      act_sync <= {act_sync[SYNC_STAGES-2:0], IOACT};
      done_sync <= {done_sync[SYNC_STAGES-2:0], IODONE};
    end

  assign act_s = act_sync[SYNC_STAGES-1];
  assign done_s = done_sync[SYNC_STAGES-1];

`ifdef IOB_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] tcnt;

  always_ff @(posedge CLK)
    if (RES || state != ACT) tcnt <= '0;
    else tcnt <= tcnt + 1'b1;

  assign abort = state == ACT && !done_s && tcnt == TW'(TIMEOUT - 1);
`else
  assign abort = 1'b0;
`endif

  // a pending promotion owns the latch for one cycle, so no new capture then
  assign IN_READY = count != 2'd2 && (!IN_RW || count == 2'd0) && !rd_out && !promo;
  assign accept = IN_VALID && IN_READY;
  assign retire = state == ACT && (done_s || abort);
  assign entry = {IN_RW, IN_LDS, IN_UDS};

  always_comb begin
    count_n = count;
    slot0_n = slot0;
    slot1_n = slot1;
    le_in_n = 1'b0;
    le_fwd_n = 1'b0;
    promo_n = 1'b0;
    if (retire) begin
      count_n = count - 2'd1;
      slot0_n = slot1;
      le_fwd_n = count == 2'd2;
      promo_n = count == 2'd2;
    end
    if (accept) begin
      slot0_n = count_n == 2'd0 ? entry : slot0_n;
      slot1_n = count_n == 2'd0 ? slot1_n : entry;
      le_fwd_n = le_fwd_n || count_n == 2'd0;
      le_in_n = 1'b1;
      count_n = count_n + 2'd1;
    end
  end

  // LE_FWD for the head is always registered before IOREQ can rise
  always_comb
    state_n = state == IDLE ? (count != 2'd0 && !le_fwd_n ? REQ : IDLE) :
              state == REQ  ? (act_s ? ACT : REQ) :
              state == ACT  ? (retire ? DONE : ACT) :
              (!act_s && !done_s ? IDLE : DONE);

  always_ff @(posedge CLK)
    if (RES) begin
      state <= IDLE;
      count <= 2'd0;
      slot0 <= 3'b000;
      slot1 <= 3'b000;
      rd_out <= 1'b0;
      promo <= 1'b0;
      LE_IN <= 1'b0;
      LE_FWD <= 1'b0;
      RD_DONE <= 1'b0;
      ERR <= 1'b0;
    end else begin
      state <= state_n;
      count <= count_n;
      slot0 <= slot0_n;
      slot1 <= slot1_n;
      rd_out <= (rd_out && !(retire && slot0[2])) || (accept && IN_RW);
      promo <= promo_n;
      LE_IN <= le_in_n;
      LE_FWD <= le_fwd_n;
      RD_DONE <= retire && slot0[2];
      ERR <= abort;
    end

  assign IOREQ = state == REQ;
  assign {IORW, IOLDS, IOUDS} = count != 2'd0 ? slot0 : 3'b000;
  assign QEMPTY = count == 2'd0 && state == IDLE;
endmodule
